// File: rtl/controller_tc1_ctrl.sv
// controller_tc1_ctrl
//
// Avalon-MM slave driving a WIDTH-bit output port. The port holds a static
// value (DATA, with bit-set / bit-clear helpers). A one-shot pulse engine
// can force a mask of bits high for a programmable number of cycles.
//
// Register map (word addresses):
//   0 DATA       RW  WIDTH bits
//   1 STATUS     RO  bit0 = busy (pulse engine active)
//   2 PULSE_LEN  RW  16 bits, taken from writedata[15:0]
//   3 PULSE_GO   WO  writedata[WIDTH-1:0] is the pulse mask
//   4 OUTSET     WO  DATA |= writedata
//   5 OUTCLEAR   WO  DATA &= ~writedata
//   6,7          reserved: read 0, writes ignored
//
// Bus handshake: there are no wait states. A write is accepted on every
// rising edge where chipselect=1 and write_n=0. Reads are not qualified:
// readdata is registered every edge from the current address, so the value
// for an address presented before edge N is visible after edge N (latency 1).
//
// Ports:
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   address      word address [2:0]
//   chipselect   slave select, qualifies writes
//   write_n      active-low write strobe
//   writedata    write data [31:0]
//   readdata     registered read data [31:0]
//   out_port     output port [WIDTH-1:0]
//   dbg_state_o  pulse engine FSM state (1 = PULSE)

module controller_tc1_ctrl #(
    parameter int               WIDTH       = 25,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             dbg_state_o
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_PULSE = 1'b1
    } state_t;

    localparam logic [2:0] A_DATA      = 3'd0;
    localparam logic [2:0] A_STATUS    = 3'd1;
    localparam logic [2:0] A_PULSE_LEN = 3'd2;
    localparam logic [2:0] A_PULSE_GO  = 3'd3;
    localparam logic [2:0] A_OUTSET    = 3'd4;
    localparam logic [2:0] A_OUTCLEAR  = 3'd5;

    state_t           state_q;
    logic [15:0]      cnt_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [15:0]      plen_q,  plen_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr;
    logic             busy;
    logic [WIDTH-1:0] wd_w;

    // Upper writedata bits beyond WIDTH (and beyond 16 for PULSE_LEN) are
    // intentionally dropped.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign wr   = chipselect & ~write_n;
    assign busy = (state_q == S_PULSE);
    assign wd_w = writedata[WIDTH-1:0];

    // ---------------- DATA register ----------------
    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (address)
                A_DATA:     data_d = wd_w;
                A_OUTSET:   data_d = data_q | wd_w;
                A_OUTCLEAR: data_d = data_q & ~wd_w;
                default:    data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    // ---------------- PULSE_LEN register ----------------
    // Updating it mid-pulse is allowed; the running count is a separate copy.
    always_comb begin
        plen_d = plen_q;
        if (wr && address == A_PULSE_LEN) begin
            plen_d = writedata[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            plen_q <= 16'd0;
        end else begin
            plen_q <= plen_d;
        end
    end

    // ---------------- Pulse engine ----------------
    // cnt_q holds the number of busy cycles still to come including the
    // current one, so leaving PULSE on cnt_q == 1 gives exactly PULSE_LEN
    // busy cycles. GO writes are only honoured from IDLE: no retrigger.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            mask_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wr && address == A_PULSE_GO && plen_q != 16'd0) begin
                        state_q <= S_PULSE;
                        cnt_q   <= plen_q;
                        mask_q  <= wd_w;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == 16'd1) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 16'd0;
                        mask_q  <= '0;
                    end else begin
                        cnt_q   <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 16'd0;
                    mask_q  <= '0;
                end
            endcase
        end
    end

    // ---------------- Read path ----------------
    always_comb begin
        readdata_d = 32'd0;
        case (address)
            A_DATA:      readdata_d = 32'(data_q);
            A_STATUS:    readdata_d = {31'd0, busy};
            A_PULSE_LEN: readdata_d = {16'd0, plen_q};
            default:     readdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= 32'd0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata    = readdata_q;
    assign out_port    = data_q | (busy ? mask_q : '0);
    assign dbg_state_o = busy;

endmodule

// File: tb/tb_controller_tc1_ctrl.sv
// Testbench for controller_tc1_ctrl: directed scenarios followed by random
// bus traffic, checked against a cycle-indexed reference model.
// The model tracks the pulse as an end cycle index, not as a countdown.

module tb_controller_tc1_ctrl;

    localparam int               WIDTH = 25;
    localparam logic [WIDTH-1:0] RV    = '0;

    logic             clk;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic             dbg_state_o;

    controller_tc1_ctrl #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .out_port    (out_port),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    longint           ec       = 0;   // clock edges seen since start
    longint           end_edge = 0;   // busy while ec < end_edge
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_mask;
    logic [15:0]      m_plen;
    logic [31:0]      exp_rd;
    logic [WIDTH-1:0] exp_out;
    logic             exp_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_data   = RV;
        m_mask   = '0;
        m_plen   = 16'd0;
        end_edge = ec;
        exp_rd   = 32'd0;
        exp_out  = RV;
        exp_busy = 1'b0;
    endtask

    // One rising edge with the given bus inputs.
    task automatic model_edge(input logic [2:0] a, input logic wr, input logic [31:0] wd);
        bit b;
        b = (ec < end_edge);
        case (a)
            3'd0:    exp_rd = 32'(m_data);
            3'd1:    exp_rd = {31'd0, b};
            3'd2:    exp_rd = {16'd0, m_plen};
            default: exp_rd = 32'd0;
        endcase
        ec = ec + 1;
        if (wr) begin
            case (a)
                3'd0: m_data = wd[WIDTH-1:0];
                3'd2: m_plen = wd[15:0];
                3'd3: if (!b && m_plen != 16'd0) begin
                    m_mask   = wd[WIDTH-1:0];
                    end_edge = ec + longint'(m_plen);
                end
                3'd4: m_data = m_data | wd[WIDTH-1:0];
                3'd5: m_data = m_data & ~wd[WIDTH-1:0];
                default: ;
            endcase
        end
        exp_busy = (ec < end_edge);
        exp_out  = m_data | (exp_busy ? m_mask : '0);
    endtask

    // ---------------- driver tasks ----------------
    // Called 1 time unit after a rising edge; drives, clocks, then checks.
    task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        @(posedge clk);
        model_edge(a, cs & ~wn, wd);
        #1;
        chk("readdata", readdata, exp_rd);
        chk("out_port", 32'(out_port), 32'(exp_out));
        chk("fsm_state", {31'd0, dbg_state_o}, {31'd0, exp_busy});
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
        step(a, 1'b1, 1'b0, wd);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        step(a, 1'b1, 1'b1, 32'd0);
    endtask

    // Reset pulse of one clock, asserted and released mid-cycle.
    task automatic do_reset();
        chipselect = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_out_async", 32'(out_port), 32'(RV));
        chk("rst_rd_async", readdata, 32'd0);
        chk("rst_state_async", {31'd0, dbg_state_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_out_held", 32'(out_port), 32'(RV));
        chk("rst_state_held", {31'd0, dbg_state_o}, 32'd0);
        reset_n = 1'b1;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hi;
        bit bit2_seen;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd", readdata, 32'd0);
        chk("reset_out", 32'(out_port), 32'(RV));
        reset_n = 1'b1;

        // All addresses read 0 after reset.
        for (int a = 0; a < 8; a++) begin
            rd_reg(3'(a));
            chk("post_reset_read", readdata, 32'd0);
        end
        chk("post_reset_out", 32'(out_port), 32'd0);

        // DATA / OUTSET / OUTCLEAR.
        wr_reg(3'd0, 32'h0000F0F);
        wr_reg(3'd4, 32'h1000000);
        wr_reg(3'd5, 32'h000000F);
        rd_reg(3'd0);
        chk("setclr_out", 32'(out_port), 32'h1000F00);
        chk("setclr_read", readdata, 32'h01000F00);

        // Basic 5-cycle pulse.
        wr_reg(3'd0, 32'd0);
        wr_reg(3'd2, 32'd5);
        wr_reg(3'd3, 32'h3);
        hi = (out_port == 25'h3) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            rd_reg(3'd1);
            if (out_port == 25'h3) hi++;
        end
        chk("pulse5_len", 32'(hi), 32'd5);
        chk("pulse5_status_after", readdata, 32'd0);

        // GO in cycle 3 and in the last cycle ignored; PULSE_LEN write mid-pulse.
        wr_reg(3'd3, 32'h3);
        bit2_seen = out_port[2];
        hi = (out_port == 25'h3) ? 1 : 0;
        rd_reg(3'd1);
        if (out_port == 25'h3) hi++;
        rd_reg(3'd1);
        if (out_port == 25'h3) hi++;
        wr_reg(3'd3, 32'h4);
        bit2_seen |= out_port[2];
        if (out_port == 25'h3) hi++;
        wr_reg(3'd2, 32'd2);
        bit2_seen |= out_port[2];
        if (out_port == 25'h3) hi++;
        wr_reg(3'd3, 32'h4);
        bit2_seen |= out_port[2];
        if (out_port == 25'h3) hi++;
        for (int i = 0; i < 4; i++) begin
            rd_reg(3'd1);
            bit2_seen |= out_port[2];
        end
        chk("noretrig_bit2", {31'd0, bit2_seen}, 32'd0);
        chk("noretrig_len", 32'(hi), 32'd5);
        rd_reg(3'd2);
        chk("plen_updated", readdata, 32'd2);

        // Zero length GO is ignored.
        wr_reg(3'd2, 32'd0);
        wr_reg(3'd3, 32'h1);
        rd_reg(3'd1);
        rd_reg(3'd1);
        chk("zero_len_status", readdata, 32'd0);
        chk("zero_len_out", 32'(out_port), 32'd0);

        // Maximum length pulse.
        wr_reg(3'd2, 32'h0001FFFF);
        wr_reg(3'd3, 32'h1);
        hi = out_port[0] ? 1 : 0;
        for (int i = 0; i < 65537; i++) begin
            step(3'd1, 1'b0, 1'b1, 32'd0);
            if (out_port[0]) hi++;
        end
        chk("max_len", 32'(hi), 32'd65535);

        // Reset mid-pulse aborts it.
        wr_reg(3'd0, 32'h0AA);
        wr_reg(3'd2, 32'd6);
        wr_reg(3'd3, 32'h1F0000);
        rd_reg(3'd1);
        chk("pre_reset_busy", readdata, 32'd1);
        do_reset();
        for (int i = 0; i < 8; i++) rd_reg(3'd1);
        chk("post_abort_status", readdata, 32'd0);
        chk("post_abort_out", 32'(out_port), 32'(RV));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  a;
            logic        cs;
            logic        wn;
            logic [31:0] wd;
            a  = 3'($urandom_range(0, 7));
            cs = ($urandom_range(0, 3) != 0);
            wn = 1'($urandom_range(0, 1));
            wd = $urandom;
            if (a == 3'd2) wd = {$urandom_range(0, 1) == 0 ? 16'hFFFF : 16'h0000,
                                 16'($urandom_range(0, 7))};
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(a, cs, wn, wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
